// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage:
//   - FSM state encoding (FETCH / HOLD / DRAIN)
//   - default bubble instruction word
//   - bit positions of the Rs / Rt register fields inside an instruction
package fetch_stage_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_FETCH = 2'd0;  // request outstanding at PC
    localparam logic [1:0] ST_HOLD  = 2'd1;  // word acked during a stall, parked in hold buffer
    localparam logic [1:0] ST_DRAIN = 2'd2;  // waiting to discard a request made stale by a redirect

    // Instruction word used for bubbles and flushes unless overridden
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Register-specifier fields fed back to the hazard unit
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register with flush and enable.
//   flush_i has priority: loads the bubble (NOP_INSTR, valid=0) and keeps the
//   previous PC+4 value. load_i captures a real instruction. Otherwise holds.
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   load_i                 capture instr_i / pcplus4_i as a valid entry
//   flush_i                insert a bubble (wins over load_i)
//   instr_i, pcplus4_i     incoming instruction and its PC+4
//   instr_o, pcplus4_o     registered instruction and PC+4
//   valid_o                1 = real instruction, 0 = bubble
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pcplus4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pcplus4_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pcplus4_q;
    logic               valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q   <= instr_i;
            pcplus4_q <= pcplus4_i;
            valid_q   <= 1'b1;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage: PC register, instruction-memory req/ack
//   handshake with a one-word hold buffer, redirect handling and the IF/ID
//   pipeline register.
// Ports
//   Clk, Rst_n                      clock, asynchronous active-low reset
//   PC_en, IF_ID_en                 stall controls from the hazard unit
//   Branch_taken, Branch_target     one-cycle redirect request and address
//   IMem_Req, IMem_Addr             fetch request (held until ack) and address
//   IMem_Ack, IMem_Rdata            read data valid strobe and data
//   IF_ID_Instr/PCPlus4/Valid       registered instruction to decode
//   IF_ID_Rs, IF_ID_Rt              register fields of IF_ID_Instr
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               PC_en,
    input  logic               IF_ID_en,
    input  logic               Branch_taken,
    input  logic [ADDR_W-1:0]  Branch_target,
    output logic               IMem_Req,
    output logic [ADDR_W-1:0]  IMem_Addr,
    input  logic               IMem_Ack,
    input  logic [INSTR_W-1:0] IMem_Rdata,
    output logic [INSTR_W-1:0] IF_ID_Instr,
    output logic [ADDR_W-1:0]  IF_ID_PCPlus4,
    output logic               IF_ID_Valid,
    output logic [4:0]         IF_ID_Rs,
    output logic [4:0]         IF_ID_Rt
);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;

    logic               fetch_active;
    logic               advance;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               ifid_load;
    logic               ifid_flush;
    logic [INSTR_W-1:0] ifid_instr_in;

    // A request is live in FETCH and DRAIN; only HOLD has nothing in flight.
    assign fetch_active = (state_q != ST_HOLD);
    assign advance      = PC_en & IF_ID_en;
    assign pc_plus4     = pc_q + ADDR_W'(4);

    // Gating with Rst_n keeps the request low during reset and lets it rise
    // in the very first cycle after release.
    assign IMem_Req  = fetch_active & Rst_n;
    // After a redirect the outstanding request keeps its original address
    // until the memory acks it, even though PC already holds the target.
    assign IMem_Addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        drain_addr_d  = drain_addr_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_instr_in = hold_q;

        if (Branch_taken) begin
            // Redirect beats everything: any data acked now is dropped.
            pc_d       = Branch_target;
            hold_d     = NOP_INSTR;
            ifid_flush = 1'b1;
            if (fetch_active && !IMem_Ack) begin
                state_d      = ST_DRAIN;
                drain_addr_d = IMem_Addr;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (advance) begin
                        ifid_load     = 1'b1;
                        ifid_instr_in = hold_q;
                        pc_d          = pc_plus4;
                        state_d       = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (IMem_Ack) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    if (IMem_Ack) begin
                        if (advance) begin
                            ifid_load     = 1'b1;
                            ifid_instr_in = IMem_Rdata;
                            pc_d          = pc_plus4;
                        end else begin
                            hold_d  = IMem_Rdata;
                            state_d = ST_HOLD;
                        end
                    end
                end
            endcase
            // Whenever IF/ID is allowed to move but no instruction goes in,
            // it takes a bubble.
            ifid_flush = IF_ID_en & ~ifid_load;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            hold_q       <= NOP_INSTR;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    if_id_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i     (Clk),
        .rst_ni    (Rst_n),
        .load_i    (ifid_load),
        .flush_i   (ifid_flush),
        .instr_i   (ifid_instr_in),
        .pcplus4_i (pc_plus4),
        .instr_o   (IF_ID_Instr),
        .pcplus4_o (IF_ID_PCPlus4),
        .valid_o   (IF_ID_Valid)
    );

    assign IF_ID_Rs = IF_ID_Instr[RS_MSB:RS_LSB];
    assign IF_ID_Rt = IF_ID_Instr[RT_MSB:RT_LSB];

endmodule
